// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply / divide unit, one bit per cycle.
// Multiply is shift-add, divide is restoring shift-subtract, both on operand
// magnitudes with a sign fix-up in the final FIX cycle.
// Optional divide datapath: define ALU_MULDIV_DIV_EN to compile it in; when
// undefined, Start with Op 10/11 is ignored.
module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             Resetb,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] BusA,
   input  logic [WIDTH-1:0] BusB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, done_q;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   // r_q: running upper partial product / partial remainder
   // l_q: multiplier shifting out / dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] r_q, r_d, l_q, l_d;
   logic [WIDTH-1:0] bm_q;       // multiplicand / divisor magnitude
   logic             neg_q;      // product or quotient must be negated

   logic             op_ok, accept, sgn_op, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   sum;
   logic [2*WIDTH-1:0] prod;

`ifdef ALU_MULDIV_DIV_EN
   logic             div_q, bzero_q, rneg_q;
   logic [WIDTH-1:0] a_q;        // raw dividend, returned on divide by zero
   logic [WIDTH:0]   sh, diff;
   logic [WIDTH-1:0] quo, rem;
   assign op_ok = 1'b1;
`else
   assign op_ok = ~Op[1];
`endif

   assign accept = Start & (state_q == IDLE) & op_ok;
   assign sgn_op = ~Op[0];
   assign a_neg  = sgn_op & BusA[WIDTH-1];
   assign b_neg  = sgn_op & BusB[WIDTH-1];
   assign a_mag  = a_neg ? -BusA : BusA;
   assign b_mag  = b_neg ? -BusB : BusB;

   // FSM next state and iteration counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // One iteration step of the active operation
   always_comb begin
      sum = {1'b0, r_q} + (l_q[0] ? {1'b0, bm_q} : '0);
      r_d = sum[WIDTH:1];
      l_d = {sum[0], l_q[WIDTH-1:1]};
`ifdef ALU_MULDIV_DIV_EN
      sh   = {r_q, l_q[WIDTH-1]};
      diff = sh - {1'b0, bm_q};
      if (div_q) begin
         // remainder always fits in WIDTH bits since it stays below the divisor
         r_d = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
         l_d = {l_q[WIDTH-2:0], ~diff[WIDTH]};
      end
`endif
   end

   // Sign fix-up and result selection applied at the FIX edge
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      prod = {r_q, l_q};
      if (neg_q) prod = -prod;
      if (state_q == FIX) begin
         hi_d = prod[2*WIDTH-1:WIDTH];
         lo_d = prod[WIDTH-1:0];
      end
`ifdef ALU_MULDIV_DIV_EN
      quo = neg_q  ? -l_q : l_q;
      rem = rneg_q ? -r_q : r_q;
      if (state_q == FIX && div_q) begin
         hi_d = bzero_q ? a_q : rem;
         lo_d = bzero_q ? '1  : quo;
      end
`endif
   end

   // Control registers: state, counter, registered Busy/Done, results
   always_ff @(posedge CLK or negedge Resetb) begin
      if (!Resetb) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_q == FIX);
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Operand latch on accept, iteration registers while running
   always_ff @(posedge CLK or negedge Resetb) begin
      if (!Resetb) begin
         r_q   <= '0;
         l_q   <= '0;
         bm_q  <= '0;
         neg_q <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
         div_q   <= 1'b0;
         bzero_q <= 1'b0;
         rneg_q  <= 1'b0;
         a_q     <= '0;
`endif
      end else if (accept) begin
         r_q   <= '0;
         l_q   <= a_mag;
         bm_q  <= b_mag;
         neg_q <= a_neg ^ b_neg;
`ifdef ALU_MULDIV_DIV_EN
         div_q   <= Op[1];
         bzero_q <= (BusB == '0);
         rneg_q  <= a_neg;
         a_q     <= BusA;
`endif
      end else if (state_q == RUN) begin
         r_q <= r_d;
         l_q <= l_d;
      end
   end

   assign Busy = busy_q;
   assign Done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv (WIDTH=32).
// Divide vectors run when ALU_MULDIV_DIV_EN is defined; otherwise the
// ignored-divide behaviour is checked instead.
module tb_alu_muldiv;
   localparam int W = 32;
   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   logic         CLK = 1'b0;
   logic         Resetb, Start;
   logic [1:0]   Op;
   logic [W-1:0] BusA, BusB, Hi, Lo;
   logic         Busy, Done;

   int n_chk = 0;
   int n_err = 0;
   int cyc;
   int seen;

   always #5 CLK = ~CLK;

   alu_muldiv #(.WIDTH(W)) dut (
      .CLK(CLK), .Resetb(Resetb), .Start(Start), .Op(Op),
      .BusA(BusA), .BusB(BusB), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // drive a Start pulse; returns #1 after the accepting edge
   task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge CLK);
      Start = 1'b1; Op = op; BusA = a; BusB = b;
      @(posedge CLK); #1;
      Start = 1'b0;
   endtask

   // count edges until Done is seen, with a bound
   task automatic wait_done(output int c);
      c = 0;
      do begin
         @(posedge CLK); #1;
         c++;
      end while (!Done && c < 200);
      if (!Done) chk("timeout", 64'd0, 64'd1);
   endtask

   task automatic run(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
      int c;
      launch(op, a, b);
      chk({tag, "_busy"}, 64'(Busy), 64'd1);
      wait_done(c);
      chk({tag, "_lat"}, 64'(c), 64'd33);
      chk({tag, "_busy_done"}, 64'(Busy), 64'd0);
      chk({tag, "_hi"}, 64'(Hi), 64'(ehi));
      chk({tag, "_lo"}, 64'(Lo), 64'(elo));
   endtask

   initial begin
      Resetb = 1'b0; Start = 1'b0; Op = 2'b00; BusA = '0; BusB = '0;
      #12;
      chk("rst_busy", 64'(Busy), 64'd0);
      chk("rst_done", 64'(Done), 64'd0);
      chk("rst_hi",   64'(Hi),   64'd0);
      chk("rst_lo",   64'(Lo),   64'd0);
      @(negedge CLK); Resetb = 1'b1;

      run("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run("mult_m3x5", MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
      run("mult_minsq", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
      run("mult_7xm1", MULT,  32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9);
      run("multu_sh",  MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780);

      // Start re-pulse while busy is ignored; Hi/Lo hold previous result
      launch(MULTU, 32'd3, 32'd4);
      repeat (9) begin @(posedge CLK); #1; end
      @(negedge CLK);
      Start = 1'b1; Op = MULTU; BusA = 32'd99; BusB = 32'd99;
      chk("hold_hi", 64'(Hi), 64'h1);
      chk("hold_lo", 64'(Lo), 64'h23456780);
      @(posedge CLK); #1;
      Start = 1'b0;
      chk("ign_busy", 64'(Busy), 64'd1);
      wait_done(cyc);
      chk("ign_hi", 64'(Hi), 64'd0);
      chk("ign_lo", 64'(Lo), 64'd12);
      // Start held in the Done cycle is accepted
      Start = 1'b1; Op = MULTU; BusA = 32'd5; BusB = 32'd6;
      @(posedge CLK); #1;
      Start = 1'b0;
      chk("b2b_busy", 64'(Busy), 64'd1);
      chk("b2b_done", 64'(Done), 64'd0);
      wait_done(cyc);
      chk("b2b_lat", 64'(cyc), 64'd33);
      chk("b2b_hi", 64'(Hi), 64'd0);
      chk("b2b_lo", 64'(Lo), 64'd30);

`ifdef ALU_MULDIV_DIV_EN
      run("div_ovf",  DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      run("div_m7_2", DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
      run("div_7_m2", DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      run("divu_7_0", DIVU, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);
      run("div_m7_0", DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
      run("divu_100", DIVU, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);
      run("restore",  MULTU, 32'd5,       32'd6,        32'h00000000, 32'h0000001E);
      launch(DIVU, 32'hDEADBEEF, 32'd3);
`else
      // divide ops are not available: Start must be ignored
      launch(DIVU, 32'd7, 32'd2);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (Busy || Done) seen++;
         @(posedge CLK); #1;
      end
      chk("nodiv_act", 64'(seen), 64'd0);
      chk("nodiv_hi", 64'(Hi), 64'd0);
      chk("nodiv_lo", 64'(Lo), 64'd30);
      launch(MULTU, 32'd7, 32'd9);
`endif

      // reset in the middle of an operation discards it
      repeat (14) begin @(posedge CLK); #1; end
      chk("pre_rst_busy", 64'(Busy), 64'd1);
      @(negedge CLK); Resetb = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(Busy), 64'd0);
      chk("mid_rst_done", 64'(Done), 64'd0);
      chk("mid_rst_hi",   64'(Hi),   64'd0);
      chk("mid_rst_lo",   64'(Lo),   64'd0);
      @(negedge CLK); Resetb = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge CLK); #1;
         if (Busy || Done) seen++;
      end
      chk("post_rst_idle", 64'(seen), 64'd0);

      run("after_rst", MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
